// File: rtl/hvac_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hvac_sequencer
//   Drives the heat / cool / fan relays from the thermostat's current and
//   desired temperature. It applies hysteresis on the call for heat or cool,
//   a fan lead purge before the compressor/burner engages, and a minimum
//   on-time. A fan lag purge follows, then a minimum-off lockout to prevent
//   short cycling.
//
// Ports
//   clk          in   system clock (100 MHz)
//   Reset        in   asynchronous, active-low reset
//   enable       in   thermostat armed; 0 requests an orderly shutdown
//   CurrentTemp  in   measured temperature, 8-bit unsigned whole degrees
//   DesiredTemp  in   setpoint, 8-bit unsigned whole degrees
//   heat_out     out  heat relay (HEAT_RUN only)
//   cool_out     out  cool relay (COOL_RUN only)
//   fan_out      out  fan relay (FAN_PRE, HEAT_RUN, COOL_RUN, FAN_POST)
//   lockout      out  high while resting after a cycle
//   state_out    out  current state code
//   run_count    out  completed RUN states, saturating at 255
// ---------------------------------------------------------------------------
module hvac_sequencer #(
    parameter int unsigned TICK_DIV = 100000000, // clk cycles per timing tick
    parameter int unsigned HYST     = 1,         // hysteresis, degrees (0..15)
    parameter int unsigned FAN_LEAD = 2,         // ticks of fan before heat/cool
    parameter int unsigned MIN_ON   = 60,        // minimum ticks in a RUN state
    parameter int unsigned FAN_LAG  = 3,         // ticks of fan after heat/cool
    parameter int unsigned MIN_OFF  = 120        // lockout ticks after FAN_POST
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic [7:0] CurrentTemp,
    input  logic [7:0] DesiredTemp,
    output logic       heat_out,
    output logic       cool_out,
    output logic       fan_out,
    output logic       lockout,
    output logic [2:0] state_out,
    output logic [7:0] run_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FAN_PRE  = 3'd1,
        HEAT_RUN = 3'd2,
        COOL_RUN = 3'd3,
        FAN_POST = 3'd4,
        REST     = 3'd5
    } state_e;

    typedef enum logic {
        MODE_HEAT = 1'b0,
        MODE_COOL = 1'b1
    } mode_e;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // ------------------------------------------------------------------
    // Tick prescaler: free-running 0..TICK_DIV-1, tick on the wrap cycle.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (tick) presc_d = '0;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    // ------------------------------------------------------------------
    // Demand evaluation, 9-bit so that 255+HYST cannot wrap.
    // ------------------------------------------------------------------
    logic [8:0] cur9, des9, hyst9;
    logic       need_heat, need_cool;
    logic       heat_sat, cool_sat;

    assign cur9      = {1'b0, CurrentTemp};
    assign des9      = {1'b0, DesiredTemp};
    assign hyst9     = 9'(HYST);
    assign need_heat = (cur9 + hyst9) < des9;
    assign need_cool = cur9 > (des9 + hyst9);
    assign heat_sat  = CurrentTemp >= DesiredTemp;
    assign cool_sat  = CurrentTemp <= DesiredTemp;

    // ------------------------------------------------------------------
    // State, timer, mode and counter registers
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [31:0] tmr_q, tmr_d;
    logic [7:0]  run_cnt_q, run_cnt_d;
    logic        heat_q, heat_d;
    logic        cool_q, cool_d;
    logic        fan_q, fan_d;
    logic        lock_q, lock_d;

    // A timed state of length N leaves on the edge that closes its Nth tick,
    // i.e. when the tick cycle arrives with N-1 ticks already counted.
    logic lead_done, lag_done, off_done, on_done;

    assign lead_done = tick && (tmr_q == 32'(FAN_LEAD - 1));
    assign lag_done  = tick && (tmr_q == 32'(FAN_LAG - 1));
    assign off_done  = tick && (tmr_q == 32'(MIN_OFF - 1));
    // MIN_ON is a floor, not an exact length: once reached it stays
    // satisfied while the room has not yet reached setpoint.
    assign on_done   = (tmr_q >= 32'(MIN_ON)) ||
                       (tick && (tmr_q == 32'(MIN_ON - 1)));

    // State register (outputs are registered alongside so they track state).
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            mode_q    <= MODE_HEAT;
            tmr_q     <= '0;
            run_cnt_q <= '0;
            heat_q    <= 1'b0;
            cool_q    <= 1'b0;
            fan_q     <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            tmr_q     <= tmr_d;
            run_cnt_q <= run_cnt_d;
            heat_q    <= heat_d;
            cool_q    <= cool_d;
            fan_q     <= fan_d;
            lock_q    <= lock_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (enable && need_heat) begin
                    mode_d  = MODE_HEAT;
                    state_d = FAN_PRE;
                end else if (enable && need_cool) begin
                    mode_d  = MODE_COOL;
                    state_d = FAN_PRE;
                end
            end
            FAN_PRE: begin
                // Demand dropping here is deliberately ignored; once the fan
                // has started the run goes ahead and MIN_ON decides the end.
                if (!enable)        state_d = FAN_POST;
                else if (lead_done) state_d = (mode_q == MODE_COOL) ? COOL_RUN : HEAT_RUN;
            end
            HEAT_RUN: begin
                if (!enable || (on_done && heat_sat)) state_d = FAN_POST;
            end
            COOL_RUN: begin
                if (!enable || (on_done && cool_sat)) state_d = FAN_POST;
            end
            FAN_POST: begin
                if (lag_done) state_d = REST;
            end
            REST: begin
                if (off_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer: zero on any state change, otherwise count ticks (saturating so
    // a long RUN never wraps back below MIN_ON).
    always_comb begin
        tmr_d = tmr_q;
        if (state_d != state_q)         tmr_d = '0;
        else if (tick && (tmr_q != '1)) tmr_d = tmr_q + 32'd1;
    end

    // Run counter bumps on the edge that leaves either RUN state.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if ((state_q == HEAT_RUN || state_q == COOL_RUN) &&
            state_d == FAN_POST && run_cnt_q != 8'hFF)
            run_cnt_d = run_cnt_q + 8'd1;
    end

    // Output logic, decoded from the next state so the registered relays
    // change on the same edge as state_out.
    always_comb begin
        heat_d = (state_d == HEAT_RUN);
        cool_d = (state_d == COOL_RUN);
        fan_d  = (state_d == FAN_PRE) || (state_d == HEAT_RUN) ||
                 (state_d == COOL_RUN) || (state_d == FAN_POST);
        lock_d = (state_d == REST);
    end

    assign heat_out  = heat_q;
    assign cool_out  = cool_q;
    assign fan_out   = fan_q;
    assign lockout   = lock_q;
    assign state_out = state_q;
    assign run_count = run_cnt_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
`timescale 1ns/1ps
module tb_hvac_sequencer;

    logic       clk = 1'b0;
    logic       Reset;
    logic       enable;
    logic [7:0] cur, des;
    logic       heat_out, cool_out, fan_out, lockout;
    logic [2:0] state_out;
    logic [7:0] run_count;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    hvac_sequencer #(
        .TICK_DIV(4), .HYST(1), .FAN_LEAD(2), .MIN_ON(5), .FAN_LAG(3), .MIN_OFF(4)
    ) dut (
        .clk(clk), .Reset(Reset), .enable(enable),
        .CurrentTemp(cur), .DesiredTemp(des),
        .heat_out(heat_out), .cool_out(cool_out), .fan_out(fan_out),
        .lockout(lockout), .state_out(state_out), .run_count(run_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until state_out == s (bounded); cnt = edges taken.
    task automatic wait_state(input logic [2:0] s, output int cnt);
        cnt = 0;
        while (state_out !== s && cnt < 200) begin
            step();
            cnt++;
        end
        chk($sformatf("reach_state_%0d", s), 32'(state_out), 32'(s));
    endtask

    // Cycles in a timed state of N ticks with TICK_DIV=4: (N-1)*4+1 .. N*4
    task automatic chk_dur(input string tag, input int cnt, input int nticks);
        chk(tag, 32'(cnt), (cnt >= (nticks - 1) * 4 + 1 && cnt <= nticks * 4) ? 32'(cnt) : 32'hFFFF_FFFF);
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st,
                            input logic h, input logic c, input logic f, input logic l);
        chk({tag, "_state"}, 32'(state_out), 32'(st));
        chk({tag, "_heat"},  32'(heat_out),  32'(h));
        chk({tag, "_cool"},  32'(cool_out),  32'(c));
        chk({tag, "_fan"},   32'(fan_out),   32'(f));
        chk({tag, "_lock"},  32'(lockout),   32'(l));
    endtask

    initial begin
        // ---------------- reset / idle ----------------
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enable = ($urandom_range(0, 1) == 1);
            cur    = 8'($urandom);
            des    = 8'($urandom);
            step();
            chk_outs("reset", 3'd0, 0, 0, 0, 0);
            chk("reset_runcnt", 32'(run_count), 0);
        end
        enable = 1'b1; cur = 8'd71; des = 8'd72;
        @(negedge clk); Reset = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk_outs("hyst_idle", 3'd0, 0, 0, 0, 0);

        // ---------------- heat cycle ----------------
        cur = 8'd70;
        step();
        chk_outs("heat_pre", 3'd1, 0, 0, 1, 0);
        cur = 8'd72;                      // satisfied at once; MIN_ON governs
        wait_state(3'd2, n); chk_dur("heat_pre_dur", n, 2);
        chk_outs("heat_run", 3'd2, 1, 0, 1, 0);
        wait_state(3'd4, n); chk_dur("heat_run_dur", n, 5);
        chk_outs("heat_post", 3'd4, 0, 0, 1, 0);
        chk("heat_runcnt", 32'(run_count), 1);
        wait_state(3'd5, n); chk_dur("heat_post_dur", n, 3);
        chk_outs("heat_rest", 3'd5, 0, 0, 0, 1);
        wait_state(3'd0, n); chk_dur("heat_rest_dur", n, 4);
        chk_outs("heat_idle", 3'd0, 0, 0, 0, 0);
        chk("heat_runcnt_end", 32'(run_count), 1);

        // ---------------- cool cycle + lockout ----------------
        cur = 8'd75;
        step();
        chk_outs("cool_pre", 3'd1, 0, 0, 1, 0);
        wait_state(3'd3, n); chk_dur("cool_pre_dur", n, 2);
        for (int i = 0; i < 24; i++) step();   // past MIN_ON, still too warm
        chk_outs("cool_hold", 3'd3, 0, 1, 1, 0);
        cur = 8'd72;
        step();
        chk_outs("cool_post", 3'd4, 0, 0, 1, 0);
        chk("cool_runcnt", 32'(run_count), 2);
        cur = 8'd75;                           // demand present across REST
        wait_state(3'd5, n); chk_dur("cool_post_dur", n, 3);
        chk_outs("cool_rest", 3'd5, 0, 0, 0, 1);
        wait_state(3'd0, n); chk_dur("cool_rest_dur", n, 4);
        chk_outs("cool_idle", 3'd0, 0, 0, 0, 0);
        step();
        chk_outs("cool_recall", 3'd1, 0, 0, 1, 0);

        // enable drop during FAN_PRE
        enable = 1'b0;
        step();
        chk_outs("pre_abort", 3'd4, 0, 0, 1, 0);
        wait_state(3'd5, n); chk_dur("pre_abort_post", n, 3);
        wait_state(3'd0, n); chk_dur("pre_abort_rest", n, 4);
        step();
        chk_outs("pre_abort_idle", 3'd0, 0, 0, 0, 0);
        chk("pre_abort_runcnt", 32'(run_count), 2);

        // ---------------- abort in HEAT_RUN ----------------
        enable = 1'b1; cur = 8'd70; des = 8'd72;
        step();
        wait_state(3'd2, n);
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0;
        step();
        chk_outs("run_abort", 3'd4, 0, 0, 1, 0);
        wait_state(3'd5, n); chk_dur("run_abort_post", n, 3);
        wait_state(3'd0, n); chk_dur("run_abort_rest", n, 4);

        // ---------------- async reset mid-FAN_PRE ----------------
        enable = 1'b1;
        step();
        chk_outs("rst_pre", 3'd1, 0, 0, 1, 0);
        #2 Reset = 1'b0;
        #1;
        chk_outs("rst_async", 3'd0, 0, 0, 0, 0);
        chk("rst_runcnt", 32'(run_count), 0);
        step(); step();
        @(negedge clk); Reset = 1'b1;
        step();
        chk_outs("rst_recall", 3'd1, 0, 0, 1, 0);
        enable = 1'b0;
        wait_state(3'd0, n);

        // ---------------- boundaries ----------------
        enable = 1'b1;
        des = 8'd255; cur = 8'd254;
        for (int i = 0; i < 3; i++) step();
        chk("bnd_no_heat", 32'(state_out), 0);
        des = 8'd254; cur = 8'd255;
        for (int i = 0; i < 3; i++) step();
        chk("bnd_no_cool", 32'(state_out), 0);
        des = 8'd0; cur = 8'd255;
        step();
        chk("bnd_cool_call", 32'(state_out), 1);
        wait_state(3'd3, n);
        chk_outs("bnd_cool_run", 3'd3, 0, 1, 1, 0);
        cur = 8'd0;
        wait_state(3'd4, n); chk_dur("bnd_cool_dur", n, 5);
        wait_state(3'd0, n);
        chk("bnd_runcnt", 32'(run_count), 1);

        // ---------------- saturation ----------------
        for (int i = 0; i < 256; i++) begin
            cur = 8'd70; des = 8'd72;
            wait_state(3'd2, n);
            cur = 8'd72;
            wait_state(3'd0, n);
        end
        chk("sat_runcnt", 32'(run_count), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
